coin_collision: RTL and testbench
=================================

# coin_collision

Detects contact between Mario's bounding box and the active coin's box once per video frame. Emits a single-cycle `reach_coin` pulse per distinct contact. Sits directly upstream of `coin_display`, which consumes `reach_coin` to hide and respawn the coin. Positions are sampled only on `frame_tick`, so mid-frame sprite updates cannot cause glitch hits.

## Interface
Parameters:
- `MARIO_W`, 16, Mario box width in pixels
- `MARIO_H`, 16, Mario box height in pixels
- `COIN_W`, 16, coin box width in pixels
- `COIN_H`, 16, coin box height in pixels
- `COOL_FRAMES`, 8, frames the detector stays blind after contact ends (0 = none)

Ports:
- `clk` in 1: system clock; single clock domain
- `rst` in 1: synchronous, active-high reset
- `frame_tick` in 1: one-cycle pulse at frame start (vblank)
- `mario_x` in 10: Mario top-left x
- `mario_y` in 10: Mario top-left y
- `coin_x` in 10: coin top-left x
- `coin_y` in 10: coin top-left y
- `coin_valid` in 1: coin currently shown and collectable
- `reach_coin` out 1: one-cycle hit pulse to `coin_display`
- `overlap` out 1: registered overlap result of the last sampled frame
- `coin_count` out 8: two BCD digits of coins collected (only with `COIN_COUNT_EN`)

## Operation
- On `frame_tick`, latch all four coordinates and `coin_valid` into sample registers.
- Overlap test:
  - x overlaps iff `mario_x < coin_x+COIN_W` and `coin_x < mario_x+MARIO_W`; y uses the same form with the H parameters.
  - Sums are computed 11 bits wide, so there is no wrap.
  - Edge-touching, where one box ends exactly where the other begins, is not an overlap.
- `overlap` = x-overlap AND y-overlap AND sampled `coin_valid`.
- FSM states and transitions. Evaluation happens only on `eval`, which is `frame_tick` delayed one cycle:
  - IDLE: on `eval` with `overlap`, go to HIT.
  - HIT: lasts exactly one cycle; `reach_coin`=1; then go to HOLD.
  - HOLD: on `eval` with `!overlap` (this includes a sampled `coin_valid`=0), load the cool counter with `COOL_FRAMES`. Go to COOL, or go straight to IDLE if `COOL_FRAMES`=0.
  - COOL: each `eval` decrements the counter. On `eval` with counter==1, go to IDLE. `overlap` is ignored while in COOL.
- `reach_coin` is decoded from state==HIT, so it is never high for two consecutive cycles.
- A Mario that stays on the coin across many frames produces exactly one pulse.
- A `frame_tick` arriving while in HIT is still sampled. Its `eval` is then handled in HOLD.

## Timing
- Reset values: state IDLE, `reach_coin`=0, `overlap`=0, sample registers 0, cool counter 0, `coin_count`=0x00.
- Latency:
  - `frame_tick` is sampled at edge T0.
  - `overlap` updates at T1.
  - State enters HIT at T2.
  - `reach_coin` is high from T2 to T3.
- `rst` asserted in any state forces the reset values at the next edge. A pending HIT is lost and no pulse is emitted.
- `frame_tick` pulses closer than 3 cycles apart are outside the supported input range; behaviour is unspecified.

## Configuration
- `COIN_COUNT_EN` defined:
  - `coin_count` is a two-digit BCD counter that increments on each HIT cycle.
  - The low digit wraps 9→0 and carries into the high digit.
  - The counter saturates at 0x99.
- `COIN_COUNT_EN` undefined: the counter logic is absent and `coin_count` is tied to 8'h00.

## Structure
- Shared package `coin_pkg`:
  - `COORD_W`=10
  - state enum `coll_state_t` {IDLE, HIT, HOLD, COOL}
  - BCD maximum constant `COIN_MAX_BCD`=8'h99
- Sub-module `box_overlap`: a purely combinational two-box intersection comparator, parameterized by the box sizes and instantiated once.

## Test plan
- Mario (100,100), coin (108,108), `coin_valid`=1, one `frame_tick` → `reach_coin` is high for exactly one cycle, 2 cycles after the tick. `overlap`=1.
- Mario (100,100), coin (116,100) (edge-touching) → `overlap`=0, no pulse.
- Overlap held for 10 frames, then released, then re-overlapped after 3 frames with `COOL_FRAMES`=8 → one pulse only. Re-overlapping after 9 clear frames → a second pulse.
- Overlap present but `coin_valid`=0 at tick → no pulse. `coin_valid` rises on the next tick → pulse.
- `rst` asserted the cycle after `frame_tick` with overlap → no pulse; all outputs 0 on the next edge.
- `COIN_COUNT_EN`, 101 separated hits → `coin_count` reads 0x09 then 0x10 at hits 9 and 10, and saturates at 0x99.

Source files
------------

// File: rtl/coin_pkg.sv
// coin_pkg: shared definitions for the coin collision detector.
//   COORD_W       screen coordinate width (10 bits covers 0..1023)
//   coll_state_t  detector FSM states
//   COIN_MAX_BCD  saturation value of the two-digit BCD coin counter
package coin_pkg;

  localparam int COORD_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    HIT,
    HOLD,
    COOL
  } coll_state_t;

  localparam logic [7:0] COIN_MAX_BCD = 8'h99;

endpackage

// File: rtl/box_overlap.sv
// box_overlap: combinational intersection test of two axis-aligned boxes.
// Box A has its top-left corner at (a_x, a_y) and size A_W x A_H. Box B has
// its top-left corner at (b_x, b_y) and size B_W x B_H.
// Ports:
//   a_x, a_y  box A top-left corner
//   b_x, b_y  box B top-left corner
//   hit       1 when the boxes share at least one pixel. Boxes that only
//             touch edges do not count as a hit.
module box_overlap
  import coin_pkg::*;
#(
  parameter int A_W = 16,
  parameter int A_H = 16,
  parameter int B_W = 16,
  parameter int B_H = 16
) (
  input  logic [COORD_W-1:0] a_x,
  input  logic [COORD_W-1:0] a_y,
  input  logic [COORD_W-1:0] b_x,
  input  logic [COORD_W-1:0] b_y,
  output logic               hit
);

  // The far edges are computed one bit wider than the coordinates. A box
  // near the right or bottom of the screen therefore cannot wrap around
  // to a small value.
  logic [COORD_W:0] a_x_end;
  logic [COORD_W:0] a_y_end;
  logic [COORD_W:0] b_x_end;
  logic [COORD_W:0] b_y_end;
  logic             x_hit;
  logic             y_hit;

  assign a_x_end = {1'b0, a_x} + (COORD_W+1)'(A_W);
  assign a_y_end = {1'b0, a_y} + (COORD_W+1)'(A_H);
  assign b_x_end = {1'b0, b_x} + (COORD_W+1)'(B_W);
  assign b_y_end = {1'b0, b_y} + (COORD_W+1)'(B_H);

  // The comparisons are strict, so boxes that only share an edge give 0.
  assign x_hit = ({1'b0, a_x} < b_x_end) && ({1'b0, b_x} < a_x_end);
  assign y_hit = ({1'b0, a_y} < b_y_end) && ({1'b0, b_y} < a_y_end);
  assign hit   = x_hit && y_hit;

endmodule

// File: rtl/coin_collision.sv
// coin_collision: checks once per video frame whether Mario touches the
// active coin. It emits a single-cycle reach_coin pulse for each distinct
// contact; the downstream coin_display uses that pulse to hide and respawn
// the coin.
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   frame_tick      one-cycle pulse at frame start. Positions are sampled
//                   only on this pulse.
//   mario_x/y       Mario top-left corner
//   coin_x/y        coin top-left corner
//   coin_valid      coin is shown and can be collected
//   reach_coin      one-cycle hit pulse, two cycles after the frame_tick edge
//   overlap         registered overlap result of the last sampled frame
//   coin_count      two BCD digits of coins collected. Build with
//                   COIN_COUNT_EN defined to get the counter; otherwise this
//                   output is 8'h00.
module coin_collision
  import coin_pkg::*;
#(
  parameter int MARIO_W     = 16,
  parameter int MARIO_H     = 16,
  parameter int COIN_W      = 16,
  parameter int COIN_H      = 16,
  parameter int COOL_FRAMES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic [COORD_W-1:0] mario_x,
  input  logic [COORD_W-1:0] mario_y,
  input  logic [COORD_W-1:0] coin_x,
  input  logic [COORD_W-1:0] coin_y,
  input  logic               coin_valid,
  output logic               reach_coin,
  output logic               overlap,
  output logic [7:0]         coin_count
);

  localparam int CNT_W = (COOL_FRAMES < 2) ? 1 : $clog2(COOL_FRAMES + 1);
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOL_FRAMES);

  logic [COORD_W-1:0] mario_x_p0;
  logic [COORD_W-1:0] mario_y_p0;
  logic [COORD_W-1:0] coin_x_p0;
  logic [COORD_W-1:0] coin_y_p0;
  logic               coin_valid_p0;
  logic               vld_p0;
  logic               vld_p1;
  logic               box_hit;
  logic               eval;
  coll_state_t        state;
  logic [CNT_W-1:0]   cool_cnt;

  // Stage p0: latch the frame snapshot on frame_tick. Sprite moves made
  // during the frame therefore cannot cause a false hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0        <= 1'b0;
      mario_x_p0    <= '0;
      mario_y_p0    <= '0;
      coin_x_p0     <= '0;
      coin_y_p0     <= '0;
      coin_valid_p0 <= 1'b0;
    end else begin
      vld_p0 <= frame_tick;
      if (frame_tick) begin
        mario_x_p0    <= mario_x;
        mario_y_p0    <= mario_y;
        coin_x_p0     <= coin_x;
        coin_y_p0     <= coin_y;
        coin_valid_p0 <= coin_valid;
      end
    end
  end

  box_overlap #(
    .A_W (MARIO_W),
    .A_H (MARIO_H),
    .B_W (COIN_W),
    .B_H (COIN_H)
  ) u_box_overlap (
    .a_x (mario_x_p0),
    .a_y (mario_y_p0),
    .b_x (coin_x_p0),
    .b_y (coin_y_p0),
    .hit (box_hit)
  );

  // Stage p1: register the overlap result of the sampled frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      overlap <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        overlap <= box_hit && coin_valid_p0;
      end
    end
  end

  // The FSM evaluates once per frame, when the fresh overlap result is
  // available.
  assign eval = vld_p1;

  // Stage p2: contact FSM. reach_coin is registered so that it is high
  // exactly while state == HIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cool_cnt   <= '0;
      reach_coin <= 1'b0;
    end else begin
      reach_coin <= 1'b0;
      case (state)
        IDLE: begin
          if (eval && overlap) begin
            state      <= HIT;
            reach_coin <= 1'b1;
          end
        end
        HIT: begin
          state <= HOLD;
        end
        HOLD: begin
          // A coin that has gone invalid also ends the contact, because
          // overlap already includes coin_valid.
          if (eval && !overlap) begin
            if (COOL_FRAMES == 0) begin
              state <= IDLE;
            end else begin
              state    <= COOL;
              cool_cnt <= COOL_LOAD;
            end
          end
        end
        COOL: begin
          // The detector is blind here: overlap is ignored until the
          // cool-down expires.
          if (eval) begin
            cool_cnt <= cool_cnt - CNT_W'(1);
            if (cool_cnt == CNT_W'(1)) begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef COIN_COUNT_EN
  logic [7:0] count_q;

  // Two-digit BCD increment that stops at 99.
  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
    logic [7:0] r;
    if (v == COIN_MAX_BCD) begin
      r = v;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 8'h00;
    end else if (state == HIT) begin
      count_q <= bcd_inc_sat(count_q);
    end
  end

  assign coin_count = count_q;
`else
  assign coin_count = 8'h00;
`endif

endmodule

// File: tb/tb_coin_collision.sv
// tb_coin_collision: directed bench for coin_collision. A frame-level
// contact model predicts overlap, reach_coin and coin_count. Literal
// checks on pulse counts and the model pin the expected behaviour.
module tb_coin_collision;

  localparam int MW   = 16;
  localparam int MH   = 16;
  localparam int CW   = 16;
  localparam int CH   = 16;
  localparam int COOL = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic [9:0] mario_x = '0;
  logic [9:0] mario_y = '0;
  logic [9:0] coin_x = '0;
  logic [9:0] coin_y = '0;
  logic       coin_valid = 1'b0;
  logic       reach_coin;
  logic       overlap;
  logic [7:0] coin_count;

  int   checks = 0;
  int   failures = 0;
  bit   chk_en = 1'b0;
  logic exp_reach = 1'b0;
  logic exp_ov = 1'b0;
  int   count_int = 0;
  int   pulses = 0;
  // Frame-level contact model: 0 = free, 1 = touching, 2 = blind.
  int   mode = 0;
  int   blind = 0;

  coin_collision #(
    .MARIO_W     (MW),
    .MARIO_H     (MH),
    .COIN_W      (CW),
    .COIN_H      (CH),
    .COOL_FRAMES (COOL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .mario_x    (mario_x),
    .mario_y    (mario_y),
    .coin_x     (coin_x),
    .coin_y     (coin_y),
    .coin_valid (coin_valid),
    .reach_coin (reach_coin),
    .overlap    (overlap),
    .coin_count (coin_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_overlap(input int mx, input int my, input int cx, input int cy,
                                       input bit v);
    return v && (mx < cx + CW) && (cx < mx + MW) && (my < cy + CH) && (cy < my + MH);
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  // The per-cycle compare against the model runs on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("reach_coin", 8'(reach_coin), 8'(exp_reach));
      check("overlap", 8'(overlap), 8'(exp_ov));
      check("coin_count", coin_count, to_bcd(count_int));
      if (reach_coin === 1'b1) pulses++;
    end
  end

  // Drives one frame. The tick edge is T0, overlap follows at T1 and the
  // pulse (if any) at T2. Ticks end up 5 cycles apart.
  task automatic frame(input int mx, input int my, input int cx, input int cy, input bit v);
    bit ov;
    bit pulse;
    @(negedge clk);
    mario_x    = 10'(mx);
    mario_y    = 10'(my);
    coin_x     = 10'(cx);
    coin_y     = 10'(cy);
    coin_valid = v;
    frame_tick = 1'b1;
    ov    = model_overlap(mx, my, cx, cy, v);
    pulse = 1'b0;
    if (mode == 0) begin
      if (ov) begin
        pulse = 1'b1;
        mode  = 1;
      end
    end else if (mode == 1) begin
      if (!ov) begin
        if (COOL == 0) mode = 0;
        else begin
          blind = COOL;
          mode  = 2;
        end
      end
    end else begin
      blind--;
      if (blind == 0) mode = 0;
    end
    @(posedge clk);
    @(negedge clk);
    frame_tick = 1'b0;
    @(posedge clk);
    exp_ov = ov;
    @(posedge clk);
    exp_reach = pulse;
    @(posedge clk);
    exp_reach = 1'b0;
`ifdef COIN_COUNT_EN
    if (pulse && count_int < 99) count_int++;
`endif
    @(posedge clk);
  endtask

  task automatic on_coin();
    frame(100, 100, 108, 108, 1'b1);
  endtask

  task automatic far(input int n);
    for (int i = 0; i < n; i++) frame(100, 100, 500, 500, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Pin the model against hand-computed geometry.
    check("model_hit", 8'(model_overlap(100, 100, 108, 108, 1'b1)), 8'h01);
    check("model_edge", 8'(model_overlap(100, 100, 116, 100, 1'b1)), 8'h00);
    check("model_nowrap", 8'(model_overlap(1015, 1015, 1020, 1020, 1'b1)), 8'h01);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
    check("rst_reach", 8'(reach_coin), 8'h00);
    check("rst_overlap", 8'(overlap), 8'h00);
    check("rst_count", coin_count, 8'h00);

    // Basic hit
    on_coin();
    check("t1_pulses", 8'(pulses), 8'd1);
    check("t1_overlap", 8'(overlap), 8'h01);

    // Mario stays on the coin for 10 frames: still a single pulse.
    repeat (9) on_coin();
    check("hold_pulses", 8'(pulses), 8'd1);

    // Release, touch again during cool-down (ignored), wait until it expires.
    far(3);
    on_coin();
    far(5);
    check("cool_pulses", 8'(pulses), 8'd1);
    on_coin();
    check("rearm_pulses", 8'(pulses), 8'd2);

    // Exactly 9 clear frames, then re-contact -> second distinct pulse.
    far(9);
    on_coin();
    check("nine_clear", 8'(pulses), 8'd3);

    // Only 8 clear frames: contact lands on the last blind frame.
    far(8);
    on_coin();
    check("eight_clear", 8'(pulses), 8'd3);
    far(1);
    on_coin();
    check("after_expiry", 8'(pulses), 8'd4);
    far(9);

    // Edge-touching on each side is not an overlap.
    frame(100, 100, 116, 100, 1'b1);
    check("edge_x_ov", 8'(overlap), 8'h00);
    frame(100, 100, 100, 116, 1'b1);
    frame(116, 100, 100, 100, 1'b1);
    frame(1023, 100, 0, 100, 1'b1);
    check("edge_pulses", 8'(pulses), 8'd4);

    // Near the screen corner the sums exceed 10 bits.
    frame(1015, 1015, 1020, 1020, 1'b1);
    check("nowrap_pulses", 8'(pulses), 8'd5);
    far(9);

    // One-pixel corner overlap.
    frame(100, 100, 115, 115, 1'b1);
    check("corner_pulses", 8'(pulses), 8'd6);
    far(9);

    // An invalid coin is not collected, even when the boxes overlap.
    frame(100, 100, 108, 108, 1'b0);
    check("invalid_ov", 8'(overlap), 8'h00);
    check("invalid_pulses", 8'(pulses), 8'd6);
    on_coin();
    check("valid_pulses", 8'(pulses), 8'd7);
    far(9);

    // Reset in the cycle after a hit tick cancels the pending pulse.
    @(negedge clk);
    mario_x = 10'd100; mario_y = 10'd100; coin_x = 10'd108; coin_y = 10'd108;
    coin_valid = 1'b1;
    frame_tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    frame_tick = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    exp_ov = 1'b0; exp_reach = 1'b0; count_int = 0; mode = 0; blind = 0;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_reach", 8'(reach_coin), 8'h00);
    check("mrst_overlap", 8'(overlap), 8'h00);
    check("mrst_count", coin_count, 8'h00);
    repeat (4) @(posedge clk);
    check("mrst_pulses", 8'(pulses), 8'd7);

`ifdef COIN_COUNT_EN
    for (int h = 1; h <= 101; h++) begin
      on_coin();
      far(9);
      if (h == 9) check("count_9", coin_count, 8'h09);
      if (h == 10) check("count_10", coin_count, 8'h10);
    end
    check("count_sat", coin_count, 8'h99);
`else
    on_coin();
    check("post_rst_pulses", 8'(pulses), 8'd8);
    check("count_off", coin_count, 8'h00);
    far(9);
`endif

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
